tff_toggle_gen: RTL
===================

// Module: tff_toggle_gen
// PURPOSE
//  Programmable toggle-enable generator: the stage directly upstream of the T flip-flop.
//  Emits single-cycle T pulses at a programmable period, either continuously or as a
//  counted burst, and drives the T input of the downstream T FF.
//  Used for clock-enable division and for bounded toggle bursts on control lines.
// PARAMETERS
//  WIDTH  8  width of period counter, burst counter, PERIOD/BURST/TCNT ports
// PORTS
//  CLK    in   1      rising-edge clock; single clock domain
//  RST_N  in   1      asynchronous, active-low reset
//  START  in   1      start request; sampled only in IDLE
//  STOP   in   1      abort request; sampled in RUN
//  EN     in   1      count enable; low freezes period counter, no T issued
//  MODE   in   1      0 = continuous, 1 = one-shot burst
//  PERIOD in   WIDTH  cycles between T pulses; latched on START
//  BURST  in   WIDTH  number of T pulses in one-shot mode; latched on START
//  T      out  1      toggle pulse to downstream T FF, one cycle wide
//  BUSY   out  1      high in RUN
//  DONE   out  1      one-cycle pulse when a one-shot burst completes or a STOP is taken
//  TCNT   out  WIDTH  T pulses issued since the last START
// BEHAVIOUR
//  Reset (RST_N low, async): state=IDLE; T=0, BUSY=0, DONE=0, TCNT=0; counters and latched
//   PERIOD/BURST = 0. Outputs are registered, so no combinational path from input to output.
//  FSM states: IDLE, RUN, FIN.
//   IDLE: START=1 and STOP=0 -> latch PERIOD, BURST, MODE; clear period count and TCNT; go to RUN.
//     START=1 and STOP=1 in the same cycle: STOP wins and the block stays in IDLE.
//     One-shot mode with BURST=0 -> go directly to FIN and issue no T.
//   RUN: BUSY=1. If EN=1, the period count increments. When the count reaches P-1, the next
//     cycle asserts T=1, the count returns to 0, and TCNT increments.
//     P = latched PERIOD. PERIOD=0 is treated as P=1, giving T every enabled cycle.
//     EN=0 freezes the count and forces T=0.
//     START in RUN is ignored. PERIOD/BURST changes in RUN have no effect until the next START.
//     One-shot: after the T that brings TCNT to BURST -> FIN.
//     Continuous: runs until STOP. TCNT wraps modulo 2^WIDTH.
//     STOP=1 -> FIN on the next edge. A T scheduled for that same edge is still issued.
//   FIN: DONE=1 for one cycle, BUSY=0, T=0 -> IDLE. TCNT holds its value until the next START.
//  Latency: START captured at edge k -> BUSY=1 after edge k. With EN held high, the first T is
//   high during cycle k+P (1-based cycles after edge k). T pulses are then exactly P cycles apart.
//  Reset asserted mid-operation aborts immediately to the reset values. No DONE is emitted.
// CONFIGURATION
//  TFF_TOGGLE_GEN_QOUT_EN defined: the block adds output ports Q and QN (1 bit each) and an
//   internal T flip-flop fed by T.
//   Q toggles on each edge where T=1 and holds otherwise; QN = ~Q at all times.
//   Reset gives Q=0, QN=1.
//  Not defined: Q/QN ports and the internal flop are absent. T is the only toggle output and
//   drives an external T FF.
// TESTING
//  1 Reset: RST_N low mid-RUN, asynchronously -> T=0, BUSY=0, DONE=0, TCNT=0 before the next edge.
//  2 One-shot: MODE=1, PERIOD=3, BURST=4, EN=1, START pulse -> 4 T pulses spaced 3 cycles apart,
//    DONE pulse, TCNT=4, BUSY low.
//  3 Continuous: MODE=0, PERIOD=0, WIDTH=8 -> T every cycle; TCNT wraps 255->0; STOP -> DONE, IDLE.
//  4 EN gating: PERIOD=4, EN low for 5 cycles mid-period -> next T delayed by exactly 5 cycles.
//  5 Corners: START+STOP together in IDLE -> stays IDLE; BURST=0 one-shot -> DONE, zero T;
//    START in RUN ignored.
//  6 With TFF_TOGGLE_GEN_QOUT_EN: BURST=3 from reset -> Q ends at 1, QN at 0. BURST=4 -> Q=0.

Source files
------------

// File: rtl/tff_toggle_gen.sv
// tff_toggle_gen: programmable toggle-enable generator feeding a downstream T flip-flop.
//
// Emits single-cycle T pulses every P enabled cycles (P = latched period, 0 treated as 1),
// either continuously until stop, or as a one-shot burst of a latched number of pulses.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   start request, sampled in idle only
//   stop    abort request, sampled in run (also blocks a start in idle)
//   en      count enable; low freezes the period count and suppresses T
//   mode    0 = continuous, 1 = one-shot burst
//   period  cycles between T pulses, latched on start
//   burst   pulse count for one-shot mode, latched on start
//   t       one-cycle toggle pulse
//   busy    high while running
//   done    one-cycle pulse when a burst completes or a stop is taken
//   tcnt    T pulses issued since the last start (wraps)
//   q, qn   internal T flop output and its complement
//           (present only with TFF_TOGGLE_GEN_QOUT_EN defined)
//
// Optional feature macro: TFF_TOGGLE_GEN_QOUT_EN
module tff_toggle_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] burst,
`ifdef TFF_TOGGLE_GEN_QOUT_EN
  output logic             q,
  output logic             qn,
`endif
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] tcnt
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] burst_q, burst_d;
  logic             mode_q, mode_d;
  logic             t_q, t_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] cnt_last;
  logic             burst_hit;

  // Terminal count value; a zero period behaves like a period of one.
  assign cnt_last  = (period_q == '0) ? '0 : period_q - WIDTH'(1);
  assign burst_hit = mode_q && (tcnt_q == burst_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    period_d = period_q;
    burst_d  = burst_q;
    mode_d   = mode_q;
    t_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          period_d = period;
          burst_d  = burst;
          mode_d   = mode;
          cnt_d    = '0;
          tcnt_d   = '0;
          // An empty burst finishes immediately without any pulse.
          state_d  = (mode && (burst == '0)) ? StFin : StRun;
        end
      end
      StRun: begin
        // Once the burst is complete no further pulse may be scheduled.
        if (en && !burst_hit) begin
          if (cnt_q == cnt_last) begin
            cnt_d  = '0;
            t_d    = 1'b1;
            tcnt_d = tcnt_q + WIDTH'(1);
          end else begin
            cnt_d  = cnt_q + WIDTH'(1);
          end
        end
        // A pulse scheduled on the stop edge is still issued.
        if (burst_hit || stop) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRun);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      period_q <= '0;
      burst_q  <= '0;
      mode_q   <= 1'b0;
      t_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      period_q <= period_d;
      burst_q  <= burst_d;
      mode_q   <= mode_d;
      t_q      <= t_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign t    = t_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tcnt = tcnt_q;

`ifdef TFF_TOGGLE_GEN_QOUT_EN
  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (t_q) begin
      q_q <= ~q_q;
    end
  end

  assign q  = q_q;
  assign qn = ~q_q;
`endif

endmodule
